// File: rtl/hack_cpu_if.sv
// Bus between the Hack core and its instruction ROM / data RAM.
// The master side is the CPU, the slave side is the memory system.
interface hack_cpu_if;
  logic [15:0] inM;
  logic [15:0] instruction;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] addressM;
  logic [15:0] pc;

  modport master (
    input  inM,
    input  instruction,
    output outM,
    output writeM,
    output addressM,
    output pc
  );

  modport slave (
    output inM,
    output instruction,
    input  outM,
    input  writeM,
    input  addressM,
    input  pc
  );
endinterface

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU core holding A, D and PC; ROM and RAM are external.
// Define HACK_CPU_STRICT_DECODE_EN to treat C-instructions with bits 14:13 != 11 as NOPs.
module hack_cpu (
  input  logic       clk,
  input  logic       reset,
  hack_cpu_if.master bus
);

`ifdef HACK_CPU_STRICT_DECODE_EN
  localparam bit StrictDecode = 1'b1;
`else
  localparam bit StrictDecode = 1'b0;
`endif

  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [14:0] pc_reg;

  logic        is_c;
  logic        exec_c;
  logic        sel_m;
  logic        zx, nx, zy, ny, f, no;
  logic        dest_a, dest_d, dest_m;
  logic        j_lt, j_eq, j_gt;

  logic [15:0] x0, x1, y0, y1, r0, result;
  logic        zr, ng;
  logic        taken;

  always_comb begin
    is_c   = bus.instruction[15];
    exec_c = is_c && (!StrictDecode || (bus.instruction[14:13] == 2'b11));
    sel_m  = bus.instruction[12];
    zx     = bus.instruction[11];
    nx     = bus.instruction[10];
    zy     = bus.instruction[9];
    ny     = bus.instruction[8];
    f      = bus.instruction[7];
    no     = bus.instruction[6];
    dest_a = bus.instruction[5];
    dest_d = bus.instruction[4];
    dest_m = bus.instruction[3];
    j_lt   = bus.instruction[2];
    j_eq   = bus.instruction[1];
    j_gt   = bus.instruction[0];
  end

  always_comb begin
    x0     = zx ? '0 : d_reg;
    x1     = nx ? ~x0 : x0;
    y0     = zy ? '0 : (sel_m ? bus.inM : a_reg);
    y1     = ny ? ~y0 : y0;
    r0     = f ? (x1 + y1) : (x1 & y1);
    result = no ? ~r0 : r0;
    zr     = (result == '0);
    ng     = result[15];
    taken  = exec_c && ((j_lt && ng) || (j_eq && zr) || (j_gt && !ng && !zr));
  end

  assign bus.outM     = result;
  assign bus.writeM   = exec_c && dest_m && !reset;
  assign bus.addressM = {1'b0, a_reg[14:0]};
  assign bus.pc       = {1'b0, pc_reg};

  // Jump target is the pre-update A, so A is read here before its own write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      d_reg  <= '0;
      pc_reg <= '0;
    end else begin
      if (!is_c) begin
        a_reg <= {1'b0, bus.instruction[14:0]};
      end else if (exec_c) begin
        if (dest_a) a_reg <= result;
        if (dest_d) d_reg <= result;
      end
      pc_reg <= taken ? a_reg[14:0] : pc_reg + 15'd1;
    end
  end

endmodule

// File: tb/tb_hack_cpu.sv
// Directed-vector bench for hack_cpu: hand-computed A/D/PC/M results per instruction.
module tb_hack_cpu;
  logic clk = 1'b0;
  logic reset;

  hack_cpu_if bus ();

  hack_cpu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [15:0] ins, input logic [15:0] m = 16'h0000);
    bus.instruction = ins;
    bus.inM         = m;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present "D" (comp=001100, no dest, no jump) so outM shows the D register.
  task automatic peek_d(input string tag, input logic [15:0] exp);
    put(16'hE300);
    check_eq(tag, bus.outM, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] dinst [3];
  logic [15:0] dval  [3];
  logic [15:0] cur;
  logic        lt, eq, gt, tk;

  initial begin
    dinst[0] = 16'hEE90; dval[0] = 16'hFFFF;  // D=-1
    dinst[1] = 16'hEA90; dval[1] = 16'h0000;  // D=0
    dinst[2] = 16'hEFD0; dval[2] = 16'h0001;  // D=1

    reset = 1'b1;
    put(16'hE308);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_writeM", {15'b0, bus.writeM}, 16'd0);
    check_eq("rst_pc", bus.pc, 16'd0);
    check_eq("rst_addr", bus.addressM, 16'd0);
    peek_d("rst_d", 16'd0);
    reset = 1'b0;
    #1;
    check_eq("pc0", bus.pc, 16'd0);

    put(16'h3039); tick;
    put(16'hEC10); tick;
    put(16'h5BA0); tick;
    put(16'hE1F0); tick;
    check_eq("ad_a", bus.addressM, 16'd11111);
    check_eq("ad_pc", bus.pc, 16'd4);
    peek_d("ad_d", 16'd11111);

    put(16'd1003); tick;
    put(16'hE308);
    check_eq("md_wr", {15'b0, bus.writeM}, 16'd1);
    check_eq("md_out", bus.outM, 16'd11111);
    check_eq("md_addr", bus.addressM, 16'd1003);
    tick;
    put(16'd1004); tick;
    put(16'hE398);
    check_eq("dm1_wr", {15'b0, bus.writeM}, 16'd1);
    check_eq("dm1_out", bus.outM, 16'd11110);
    check_eq("dm1_addr", bus.addressM, 16'd1004);
    tick;
    peek_d("dm1_d", 16'd11110);
    check_eq("dm1_pc", bus.pc, 16'd8);

    put(16'd1000); tick;
    put(16'hF4F0, 16'd11111);
    check_eq("dmm_out", bus.outM, 16'hFFFF);
    tick;
    check_eq("dmm_a", bus.addressM, 16'h7FFF);
    peek_d("dmm_d", 16'hFFFF);
    put(16'd14); tick;
    put(16'hE304); tick;
    check_eq("jlt_pc", bus.pc, 16'd14);

    cur = 16'd14;
    for (int k = 0; k < 3; k++) begin
      put(16'd1000); tick; cur = cur + 16'd1;
      put(dinst[k]); tick; cur = cur + 16'd1;
      peek_d($sformatf("jm_d%0d", k), dval[k]);
      lt = dval[k][15];
      eq = (dval[k] == 16'd0);
      gt = !lt && !eq;
      for (int j = 1; j < 8; j++) begin
        tk = (j[2] && lt) || (j[1] && eq) || (j[0] && gt);
        put(16'hE300 | 16'(j)); tick;
        cur = tk ? 16'd1000 : cur + 16'd1;
        check_eq($sformatf("jm_d%0d_j%0d", k, j), bus.pc, cur);
      end
    end

    put(16'd100); tick;
    put(16'hEFE7); tick;
    check_eq("oldA_pc", bus.pc, 16'd100);
    check_eq("oldA_a", bus.addressM, 16'd1);

    put(16'h7FFF); tick;
    put(16'hEA87); tick;
    check_eq("wrap_top", bus.pc, 16'h7FFF);
    put(16'h0000); tick;
    check_eq("wrap_zero", bus.pc, 16'd0);

    put(16'hEE90); tick;
    put(16'd2); tick;
    put(16'hE0B8);
    check_eq("amd_out", bus.outM, 16'd1);
    check_eq("amd_wr", {15'b0, bus.writeM}, 16'd1);
    check_eq("amd_addr", bus.addressM, 16'd2);
    tick;
    check_eq("amd_a", bus.addressM, 16'd1);
    peek_d("amd_d", 16'd1);
    check_eq("amd_pc", bus.pc, 16'd3);

    put(16'd50); tick;
    reset = 1'b1;
    put(16'hE30F);
    check_eq("mrst_wr", {15'b0, bus.writeM}, 16'd0);
    tick;
    reset = 1'b0;
    #1;
    check_eq("mrst_pc", bus.pc, 16'd0);
    check_eq("mrst_a", bus.addressM, 16'd0);
    peek_d("mrst_d", 16'd0);

    put(16'd7); tick;
    put(16'hA30F);
`ifdef HACK_CPU_STRICT_DECODE_EN
    check_eq("nop_wr", {15'b0, bus.writeM}, 16'd0);
    tick;
    check_eq("nop_pc", bus.pc, 16'd2);
`else
    check_eq("loose_wr", {15'b0, bus.writeM}, 16'd1);
    tick;
    check_eq("loose_pc", bus.pc, 16'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
